// File: rtl/mux2_tdm_driver.sv
// mux2_tdm_driver: accepts one word per channel over two valid/ready ports,
// double-buffers them and serializes both MSB-first as an alternating
// ch0/ch1 time-division stream for a downstream 2:1 mux.
module mux2_tdm_driver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ch0_data,
    input  logic             ch0_valid,
    output logic             ch0_ready,
    input  logic [WIDTH-1:0] ch1_data,
    input  logic             ch1_valid,
    output logic             ch1_ready,
    output logic             i0,
    output logic             i1,
    output logic             s,
    output logic             frame_start,
    output logic             busy
);

    localparam int SLOTS = 2 * WIDTH;
    localparam int SW    = $clog2(SLOTS);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state_reg, state_next;
    logic [SW-1:0] slot_reg, slot_next;

    // Per-channel views so both channels share one generate body.
    logic [1:0][WIDTH-1:0] in_data;
    logic [1:0]            in_valid;
    logic [1:0]            full_w;
    logic [1:0]            msb_w;
    logic [1:0]            ready_w;

    // Frame control: load moves both holding words into the shifters,
    // shift_en advances both shifters after each odd slot.
    logic load;
    logic shift_en;
    logic both_full;
    logic last_slot;

    assign in_data   = {ch1_data, ch0_data};
    assign in_valid  = {ch1_valid, ch0_valid};
    assign both_full = full_w[0] & full_w[1];
    assign last_slot = (slot_reg == SW'(SLOTS - 1));

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic [WIDTH-1:0] hold_reg;
            logic             hold_full_reg;
            logic [WIDTH-1:0] sh_reg;

            // Holding register and shifter for one channel. A move and a new
            // handshake can never coincide because ready is the inverse of full.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    hold_reg      <= '0;
                    hold_full_reg <= 1'b0;
                    sh_reg        <= '0;
                end else begin
                    if (load) begin
                        hold_full_reg <= 1'b0;
                    end else if (in_valid[gi] && !hold_full_reg) begin
                        hold_reg      <= in_data[gi];
                        hold_full_reg <= 1'b1;
                    end

                    if (load) begin
                        sh_reg <= hold_reg;
                    end else if (shift_en) begin
                        sh_reg <= {sh_reg[WIDTH-2:0], 1'b0};
                    end
                end
            end

            assign full_w[gi]  = hold_full_reg;
            assign msb_w[gi]   = sh_reg[WIDTH-1];
            // Ready is forced low while reset is held so nothing is offered
            // a handshake that would be discarded anyway.
            assign ready_w[gi] = rst_n & ~hold_full_reg;
        end
    endgenerate

    // State and slot counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            slot_reg  <= '0;
        end else begin
            state_reg <= state_next;
            slot_reg  <= slot_next;
        end
    end

    // Next-state logic: a frame starts only when both channels hold a word;
    // at the last slot a waiting pair is reloaded for gap-free frames.
    always_comb begin
        state_next = state_reg;
        slot_next  = slot_reg;
        load       = 1'b0;
        shift_en   = 1'b0;
        case (state_reg)
            IDLE: begin
                slot_next = '0;
                if (both_full) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (last_slot) begin
                    slot_next = '0;
                    if (both_full) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    slot_next = slot_reg + SW'(1);
                    shift_en  = slot_reg[0];
                end
            end
            default: begin
                state_next = IDLE;
                slot_next  = '0;
            end
        endcase
    end

    // Outputs decoded from registered state only.
    assign busy        = (state_reg == SHIFT);
    assign s           = busy & slot_reg[0];
    assign i0          = busy & msb_w[0];
    assign i1          = busy & msb_w[1];
    assign frame_start = busy & (slot_reg == '0);
    assign ch0_ready   = ready_w[0];
    assign ch1_ready   = ready_w[1];

endmodule

// File: tb/tb_mux2_tdm_driver.sv
// Testbench for mux2_tdm_driver: a directed vector table, hand-written
// multi-cycle sequences and a randomized phase, all compared every cycle
// against a frame-level reference model.
module tb_mux2_tdm_driver;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] ch0_data = '0;
    logic [W-1:0] ch1_data = '0;
    logic         ch0_valid = 1'b0;
    logic         ch1_valid = 1'b0;
    logic         ch0_ready, ch1_ready;
    logic         i0, i1, s, frame_start, busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    mux2_tdm_driver #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch0_data   (ch0_data),
        .ch0_valid  (ch0_valid),
        .ch0_ready  (ch0_ready),
        .ch1_data   (ch1_data),
        .ch1_valid  (ch1_valid),
        .ch1_ready  (ch1_ready),
        .i0         (i0),
        .i1         (i1),
        .s          (s),
        .frame_start(frame_start),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    endtask

    // ---------------- reference model ----------------
    // A frame is two words plus a position 0..2W-1 in the 2W-slot stream;
    // each channel has at most one waiting word.
    logic [1:0]        m_held  = '0;
    logic [1:0][W-1:0] m_hword = '0;
    logic [1:0][W-1:0] m_fword = '0;
    logic              m_active = 1'b0;
    int                m_pos    = 0;
    logic              m_live   = 1'b0;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        m_live <= 1'b1;
        if (!rst_n) begin
            m_held   <= '0;
            m_hword  <= '0;
            m_active <= 1'b0;
            m_pos    <= 0;
        end else begin
            if (!m_active || m_pos == 2 * W - 1) begin
                if (m_held == 2'b11) begin
                    m_fword  <= m_hword;
                    m_active <= 1'b1;
                    m_pos    <= 0;
                end else begin
                    m_active <= 1'b0;
                    m_pos    <= 0;
                end
            end else begin
                m_pos <= m_pos + 1;
            end
            // a word handed over at the frame start leaves the holding slot
            if ((!m_active || m_pos == 2 * W - 1) && m_held == 2'b11) m_held <= '0;
            if (ch0_valid && !m_held[0]) begin
                m_held[0]  <= 1'b1;
                m_hword[0] <= ch0_data;
            end
            if (ch1_valid && !m_held[1]) begin
                m_held[1]  <= 1'b1;
                m_hword[1] <= ch1_data;
            end
        end
    end

    // Continuous comparison of all outputs against the model, mid-cycle.
    always @(negedge clk) begin
        if (m_live) begin
            logic [6:0] exp;
            int         bit_idx;
            bit_idx = W - 1 - m_pos / 2;
            exp = {m_active & m_fword[0][bit_idx],
                   m_active & m_fword[1][bit_idx],
                   m_active & (m_pos % 2 == 1),
                   m_active & (m_pos == 0),
                   m_active,
                   rst_n & ~m_held[0],
                   rst_n & ~m_held[1]};
            check("model{i0,i1,s,fs,busy,rdy0,rdy1}",
                  32'({i0, i1, s, frame_start, busy, ch0_ready, ch1_ready}), 32'(exp));
        end
    end

    // ---------------- directed helpers ----------------
    typedef struct {
        logic         v0;
        logic [W-1:0] d0;
        logic         v1;
        logic [W-1:0] d1;
        logic [5:0]   exp; // {busy, frame_start, s, mux_out, ch0_ready, ch1_ready}
    } vec_t;

    vec_t tbl[18];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ch0_valid = 1'b0;
        ch1_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        check("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    logic [15:0] mux_bits;
    int          t1, t2, t_fs, t_rdy;
    logic        seen, busy_gap;

    initial begin
        // ---- vector table: single frame A5 / 3C ----
        mux_bits = 16'b1000_1101_0111_0010;
        tbl[0] = '{1'b1, 8'hA5, 1'b1, 8'h3C, 6'b000000};
        for (int k = 0; k < 16; k++) begin
            tbl[k + 1] = '{1'b0, 8'h00, 1'b0, 8'h00,
                           {1'b1, (k == 0), (k % 2 == 1), mux_bits[15 - k], 1'b1, 1'b1}};
        end
        tbl[17] = '{1'b0, 8'h00, 1'b0, 8'h00, 6'b000011};

        // ---- reset with random inputs ----
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ch0_valid = 1'($urandom);
            ch1_valid = 1'($urandom);
            ch0_data  = W'($urandom);
            ch1_data  = W'($urandom);
            step();
            check("reset_outputs", 32'({i0, i1, s, frame_start, busy, ch0_ready, ch1_ready}), 32'd0);
        end
        idle_inputs();
        rst_n = 1'b1;
        step();
        check("post_reset_ready", 32'({ch0_ready, ch1_ready}), 32'b11);
        check("post_reset_busy", 32'(busy), 32'd0);

        // ---- table-driven single frame ----
        for (int r = 0; r < 18; r++) begin
            ch0_valid = tbl[r].v0;
            ch0_data  = tbl[r].d0;
            ch1_valid = tbl[r].v1;
            ch1_data  = tbl[r].d1;
            step();
            check($sformatf("frame_row%0d", r),
                  32'({busy, frame_start, s, (s ? i1 : i0), ch0_ready, ch1_ready}),
                  32'(tbl[r].exp));
        end
        idle_inputs();

        // ---- back-to-back frames ----
        ch0_valid = 1'b1; ch0_data = 8'hFF;
        ch1_valid = 1'b1; ch1_data = 8'h00;
        step();
        idle_inputs();
        step();
        check("b2b_first_start", 32'(frame_start), 32'd1);
        t1 = cyc;
        ch0_valid = 1'b1; ch0_data = 8'h0F;
        ch1_valid = 1'b1; ch1_data = 8'hF0;
        step();
        idle_inputs();
        seen = 1'b0; busy_gap = 1'b0; t2 = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            step();
            if (!busy) busy_gap = 1'b1;
            if (frame_start) begin
                seen = 1'b1;
                t2 = cyc;
            end
        end
        check("b2b_second_seen", 32'(seen), 32'd1);
        check("b2b_spacing", 32'(t2 - t1), 32'd16);
        check("b2b_no_gap", 32'(busy_gap), 32'd0);
        wait_idle(40);

        // ---- single channel ----
        ch0_valid = 1'b1; ch0_data = 8'h81;
        step();
        idle_inputs();
        check("single_ready0", 32'(ch0_ready), 32'd0);
        busy_gap = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (busy) busy_gap = 1'b1;
        end
        check("single_no_start", 32'({busy_gap, busy}), 32'd0);
        ch1_valid = 1'b1; ch1_data = 8'h7E;
        step();
        idle_inputs();
        check("single_still_idle", 32'(busy), 32'd0);
        step();
        check("single_start", 32'({frame_start, i0, i1}), 32'b110);
        wait_idle(40);

        // ---- backpressure ----
        ch0_valid = 1'b1; ch0_data = 8'h11;
        ch1_valid = 1'b1; ch1_data = 8'h22;
        step();
        idle_inputs();
        step();                                 // frame 1 starts
        ch0_valid = 1'b1; ch0_data = 8'h33;
        ch1_valid = 1'b1; ch1_data = 8'h44;
        step();                                 // second pair held
        ch1_valid = 1'b0;
        ch0_data  = 8'h55;                      // third ch0 word waits
        t_fs = -1; t_rdy = -1; busy_gap = 1'b0;
        for (int k = 0; k < 40 && t_rdy < 0; k++) begin
            step();
            if (frame_start && t_fs < 0) t_fs = cyc;
            if (ch0_ready) t_rdy = cyc;
        end
        check("bp_ready_after_reload", 32'(t_rdy), 32'(t_fs));
        check("bp_reload_seen", 32'(t_fs > 0), 32'd1);
        step();                                 // 0x55 accepted here
        ch0_valid = 1'b0;
        check("bp_word_taken", 32'(ch0_ready), 32'd0);

        // ---- mid-frame reset with a pending pair ----
        ch1_valid = 1'b1; ch1_data = 8'h66;
        step();
        ch1_valid = 1'b0;
        while (cyc < t_fs + 7) step();
        check("mid_slot7_s", 32'({busy, s}), 32'b11);
        rst_n = 1'b0;
        step();
        check("mid_reset_clear", 32'({i0, i1, s, frame_start, busy, ch0_ready, ch1_ready}), 32'd0);
        rst_n = 1'b1;
        busy_gap = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (busy) busy_gap = 1'b1;
        end
        check("mid_no_resume", 32'(busy_gap), 32'd0);

        // ---- randomized traffic against the model ----
        for (int k = 0; k < 3000; k++) begin
            ch0_valid = ($urandom_range(0, 99) < 40);
            ch1_valid = ($urandom_range(0, 99) < 40);
            ch0_data  = W'($urandom);
            ch1_data  = W'($urandom);
            rst_n     = ($urandom_range(0, 299) != 0);
            step();
        end
        rst_n = 1'b1;
        idle_inputs();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
